// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t    : controller FSM state encoding
//   RUN_CYCLES : number of add/shift iterations (one per multiplier bit)
//   COUNT_W    : width of the iteration counter
package shift_add_multiplier_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   localparam int unsigned RUN_CYCLES = 8;
   localparam int unsigned COUNT_W    = $clog2(RUN_CYCLES);

endpackage

// File: rtl/binary_adder.sv
// 8-bit ripple-carry adder.
//   A, B : addends
//   Cin  : carry in
//   SUM  : A + B + Cin, low 8 bits
//   Cout : carry out of bit 7
module binary_adder (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [7:0] SUM,
   output logic       Cout
);

   logic [8:0] carry;

   always_comb begin
      carry    = '0;
      SUM      = '0;
      carry[0] = Cin;
      for (int i = 0; i < 8; i++) begin
         SUM[i]       = A[i] ^ B[i] ^ carry[i];
         carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
      end
      Cout = carry[8];
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : accepted only in idle; captures A and B
//   A, B  : multiplicand / multiplier
//   busy  : high during the eight iteration cycles
//   done  : one-cycle pulse when P holds a new product
//   P     : product, held until the next completion or reset
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        busy,
   output logic        done,
   output logic [15:0] P
);

   localparam logic [COUNT_W-1:0] CountLast = COUNT_W'(RUN_CYCLES - 1);

   state_t             state;
   logic [7:0]         mcand;
   logic [7:0]         mq;
   logic [7:0]         acc;
   logic [COUNT_W-1:0] count;

   logic [7:0]         add_b;
   logic [7:0]         sum;
   logic               cout;
   logic [15:0]        shifted;

   // Adding zero when mq[0] is clear passes acc through and yields Cout = 0.
   assign add_b = mcand & {8{mq[0]}};

   binary_adder u_adder (
      .A    (acc),
      .B    (add_b),
      .Cin  (1'b0),
      .SUM  (sum),
      .Cout (cout)
   );

   // 17-bit {Cout, SUM, mq} shifted right by one.
   assign shifted = {cout, sum, mq[7:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
         mcand <= '0;
         mq    <= '0;
         acc   <= '0;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         P     <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  mcand <= A;
                  mq    <= B;
                  acc   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
               end
            end
            StRun: begin
               {acc, mq} <= shifted;
               count     <= count + 1'b1;
               if (count == CountLast) begin
                  P     <= shifted;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
               end
            end
            StDone: begin
               done  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [15:0] P;

   int passed;
   int total;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[8];

   shift_add_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .P     (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Starts at the first negedge (idle), accepts on the following posedge (cycle k),
   // checks busy over cycles k+1..k+8 and done/P in cycle k+9, then returns.
   // poke > 0 pulses start with A=3,B=3 during RUN cycle 'poke'.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input int poke);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A     = 8'($urandom);
      B     = 8'($urandom);
      for (int i = 1; i <= 8; i++) begin
         check("run_busy", 32'(busy), 32'd1);
         check("run_done", 32'(done), 32'd0);
         if (i == poke) begin
            start = 1'b1;
            A     = 8'd3;
            B     = 8'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_busy", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd1);
      check("product", 32'(P), 32'(exp));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      A      = '0;
      B      = '0;

      vecs[0] = '{8'd1,   8'd1,   16'h0001};
      vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
      vecs[2] = '{8'hFF,  8'h00,  16'h0000};
      vecs[3] = '{8'd13,  8'd11,  16'd143};
      vecs[4] = '{8'h80,  8'h02,  16'h0100};
      vecs[5] = '{8'h00,  8'h00,  16'h0000};
      vecs[6] = '{8'd200, 8'd3,   16'd600};
      vecs[7] = '{8'h01,  8'hFF,  16'h00FF};

      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_p", 32'(P), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_hold_p", 32'(P), 32'd0);
      check("idle_hold_busy", 32'(busy), 32'd0);

      // Back-to-back: each call starts at the earliest legal edge after the previous one.
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0);

      // P must hold through idle cycles.
      repeat (3) @(negedge clk);
      check("p_hold", 32'(P), 32'h00FF);
      check("p_hold_done", 32'(done), 32'd0);

      // start during RUN is ignored, not queued.
      run_op(8'd5, 8'd7, 16'd35, 3);
      @(negedge clk);
      check("no_queue_busy", 32'(busy), 32'd0);
      check("no_queue_done", 32'(done), 32'd0);
      @(negedge clk);
      check("no_queue_busy2", 32'(busy), 32'd0);
      check("no_queue_p", 32'(P), 32'd35);

      // Reset in the middle of RUN for 9*9.
      A     = 8'd9;
      B     = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy_before_rst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_p", 32'(P), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen_done;
         int seen_busy;
         seen_done = 0;
         seen_busy = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
         end
         check("rst_no_done", 32'(seen_done), 32'd0);
         check("rst_no_busy", 32'(seen_busy), 32'd0);
      end
      check("rst_p_after", 32'(P), 32'd0);
      run_op(8'd2, 8'd3, 16'd6, 0);

      // Random operand pairs against the reference product.
      for (int n = 0; n < 1000; n++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(ra, rb, 16'(ra) * 16'(rb), 0);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
